// File: rtl/fmul_issue_arb.sv
// fmul_issue_arb
// Issue arbiter and pipeline controller for the shared pipelined
// single-precision multiplier. Two requesters are granted round-robin.
// The winning operand pair is steered into the multiplier's first rank.
// A valid/ID bit travels alongside each register rank. Completed products
// leave on one result channel that supports backpressure.
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A producer holding valid keeps
// its payload stable until that edge. req*_ready is a combinational function
// of req*_valid, res_ready, flush and internal state, and never feeds back
// into any input. On the result side, res_valid/res_id/res_z depend only on
// registered state and on mul_z. Both stay stable while res_ready is low,
// because the whole pipeline is then frozen.
module fmul_issue_arb #(
    parameter int STAGES = 3
) (
    input  logic        clk,
    input  logic        clrn,

    input  logic        req0_valid,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_rm,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_rm,
    output logic        req1_ready,

    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic [1:0]  mul_rm,
    output logic        mul_e,
    input  logic [31:0] mul_z,

    input  logic        flush,

    output logic        res_valid,
    output logic        res_id,
    output logic [31:0] res_z,
    input  logic        res_ready,

    output logic        busy
);

    // Bit k tracks multiplier rank k+1. The top bit is the rank that drives mul_z.
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] id_q;
    // Round-robin pointer: the requester that wins when both are asking.
    logic              rr_q;

    logic              advance;
    logic              grant0;
    logic              grant1;
    logic              any_grant;

    // The pipeline moves whenever the output rank is empty or is being drained.
    // A bubble in the last rank therefore never stalls upstream work.
    assign mul_e   = ~v_q[STAGES-1] | res_ready;
    assign advance = mul_e & ~flush;

    // Grant at most one requester. A lone requester always wins; a tie goes to rr_q.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (advance) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~rr_q;
                grant1 = rr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign any_grant  = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Steer the granted pair into the multiplier. The operands are zero when idle,
    // so the datapath does not toggle on stale requester values.
    always_comb begin
        mul_a  = '0;
        mul_b  = '0;
        mul_rm = '0;
        if (grant0) begin
            mul_a  = req0_a;
            mul_b  = req0_b;
            mul_rm = req0_rm;
        end else if (grant1) begin
            mul_a  = req1_a;
            mul_b  = req1_b;
            mul_rm = req1_rm;
        end
    end

    // Shift valid/ID tags in lockstep with the multiplier ranks. Flush clears
    // every valid tag but leaves the priority pointer alone.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            v_q  <= '0;
            id_q <= '0;
        end else if (flush) begin
            v_q  <= '0;
        end else if (mul_e) begin
            v_q[0]  <= any_grant;
            id_q[0] <= grant1;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k]  <= v_q[k-1];
                id_q[k] <= id_q[k-1];
            end
        end
    end

    // Hand priority to the other requester after each grant.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rr_q <= 1'b0;
        end else if (any_grant) begin
            rr_q <= ~grant1;
        end
    end

    assign res_valid = v_q[STAGES-1];
    assign res_id    = id_q[STAGES-1];
    assign res_z     = mul_z;
    assign busy      = |v_q;

endmodule

// File: tb/tb_fmul_issue_arb.sv
// Directed bench for fmul_issue_arb with a small behavioural model of the
// pipelined multiplier. The model is exact for the normal operands used here.
module tb_fmul_issue_arb;

    localparam int STAGES = 3;

    logic        clk;
    logic        clrn;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [1:0]  req0_rm;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [1:0]  req1_rm;
    logic        req1_ready;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [1:0]  mul_rm;
    logic        mul_e;
    logic [31:0] mul_z;
    logic        flush;
    logic        res_valid;
    logic        res_id;
    logic [31:0] res_z;
    logic        res_ready;
    logic        busy;

    int tests;
    int fails;

    // Scoreboard entries are {id, product}.
    logic [32:0] exp_q[$];

    fmul_issue_arb #(.STAGES(STAGES)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_rm    (req0_rm),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_rm    (req1_rm),
        .req1_ready (req1_ready),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_rm     (mul_rm),
        .mul_e      (mul_e),
        .mul_z      (mul_z),
        .flush      (flush),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_z      (res_z),
        .res_ready  (res_ready),
        .busy       (busy)
    );

    // Clock: rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier product for normal operands. Zero operands give a signed zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        int          e;
        logic        s;
        s = a[31] ^ b[31];
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {s, 31'd0};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            e = e + 1;
            return {s, e[7:0], m[46:24]};
        end
        return {s, e[7:0], m[45:23]};
    endfunction

    // Multiplier pipeline model: STAGES ranks sharing one enable.
    logic [31:0] mrank [STAGES];
    always @(posedge clk) begin
        if (mul_e) begin
            mrank[0] <= fp_mul(mul_a, mul_b);
            for (int k = 1; k < STAGES; k++) mrank[k] <= mrank[k-1];
        end
    end
    assign mul_z = mrank[STAGES-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        req0_valid = v;
        req0_a     = a;
        req0_b     = b;
        req0_rm    = rm;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
        req1_valid = v;
        req1_a     = a;
        req1_b     = b;
        req1_rm    = rm;
    endtask

    // Compare the result channel against the oldest scoreboard entry and consume it.
    task automatic check_result(input string tag);
        logic [32:0] e;
        chk1({tag, "_pending"}, exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk1({tag, "_valid"}, res_valid, 1'b1);
            chk1({tag, "_id"}, res_id, e[32]);
            chk32({tag, "_z"}, res_z, e[31:0]);
        end
    endtask

    // Drain with res_ready high, bounded by a cycle budget.
    task automatic drain(input string tag, input int bound);
        res_ready = 1'b1;
        for (int i = 0; i < bound; i++) begin
            if (exp_q.size() == 0) break;
            if (res_valid) check_result(tag);
            tick();
            settle();
        end
        chk32({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        chk1({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clrn = 1'b0;
        flush = 1'b0;
        res_ready = 1'b0;
        drive0(1'b0, 32'd0, 32'd0, 2'd0);
        drive1(1'b0, 32'd0, 32'd0, 2'd0);
        settle();

        // Reset state
        chk1("rst_res_valid", res_valid, 1'b0);
        chk1("rst_res_id", res_id, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mul_e", mul_e, 1'b1);
        drive0(1'b1, 32'h3FC00000, 32'h40000000, 2'd0);
        drive1(1'b1, 32'h40000000, 32'h40000000, 2'd1);
        settle();
        chk1("rst_req0_ready", req0_ready, 1'b1);
        chk1("rst_req1_ready", req1_ready, 1'b0);
        chk32("rst_mul_a", mul_a, 32'h3FC00000);
        drive0(1'b0, 32'd0, 32'd0, 2'd0);
        drive1(1'b0, 32'd0, 32'd0, 2'd0);
        tick();
        tick();
        clrn = 1'b1;
        settle();

        // Single issue: 1.5 x 2.0, latency STAGES
        res_ready = 1'b1;
        drive0(1'b1, 32'h3FC00000, 32'h40000000, 2'd1);
        settle();
        chk1("single_req0_ready", req0_ready, 1'b1);
        chk1("single_req1_ready", req1_ready, 1'b0);
        chk32("single_mul_a", mul_a, 32'h3FC00000);
        chk32("single_mul_b", mul_b, 32'h40000000);
        chk32("single_mul_rm", 32'(mul_rm), 32'd1);
        exp_q.push_back({1'b0, 32'h40400000});
        tick();
        drive0(1'b0, 32'd0, 32'd0, 2'd0);
        settle();
        chk1("single_lat1_valid", res_valid, 1'b0);
        chk1("single_lat1_busy", busy, 1'b1);
        tick();
        settle();
        chk1("single_lat2_valid", res_valid, 1'b0);
        tick();
        settle();
        check_result("single");
        tick();
        settle();
        chk1("single_after_valid", res_valid, 1'b0);
        chk1("single_after_busy", busy, 1'b0);

        // Requester 1 alone: 3.0 x 3.0 (also moves priority back to requester 0)
        drive1(1'b1, 32'h40400000, 32'h40400000, 2'd2);
        settle();
        chk1("single1_req1_ready", req1_ready, 1'b1);
        chk32("single1_mul_a", mul_a, 32'h40400000);
        chk32("single1_mul_rm", 32'(mul_rm), 32'd2);
        exp_q.push_back({1'b1, 32'h41100000});
        tick();
        drive1(1'b0, 32'd0, 32'd0, 2'd0);
        settle();
        drain("single1", 10);

        // Fairness: both requesters valid for 8 cycles, grants alternate 0,1,...
        drive0(1'b1, 32'h40000000, 32'h40400000, 2'd0);
        drive1(1'b1, 32'h3FC00000, 32'h3FC00000, 2'd3);
        for (int i = 0; i < 8; i++) begin
            settle();
            chk1("fair_req0_ready", req0_ready, (i % 2) == 0);
            chk1("fair_req1_ready", req1_ready, (i % 2) == 1);
            chk1("fair_res_valid", res_valid, i >= 3);
            if ((i % 2) == 0) exp_q.push_back({1'b0, 32'h40C00000});
            else              exp_q.push_back({1'b1, 32'h40100000});
            if (i >= 3) check_result("fair");
            tick();
        end
        drive0(1'b0, 32'd0, 32'd0, 2'd0);
        drive1(1'b0, 32'd0, 32'd0, 2'd0);
        settle();
        drain("fair_tail", 10);

        // Backpressure: fill three ranks, then stall the consumer for 5 cycles
        res_ready = 1'b1;
        drive0(1'b1, 32'h3F800000, 32'h40000000, 2'd0);
        settle();
        chk1("bp_fill0_ready", req0_ready, 1'b1);
        exp_q.push_back({1'b0, 32'h40000000});
        tick();
        drive0(1'b1, 32'h3FC00000, 32'h40000000, 2'd0);
        settle();
        chk1("bp_fill1_ready", req0_ready, 1'b1);
        exp_q.push_back({1'b0, 32'h40400000});
        tick();
        drive0(1'b1, 32'h40000000, 32'h40400000, 2'd0);
        settle();
        chk1("bp_fill2_ready", req0_ready, 1'b1);
        exp_q.push_back({1'b0, 32'h40C00000});
        tick();
        res_ready = 1'b0;
        drive1(1'b1, 32'h40000000, 32'h40000000, 2'd0);
        for (int i = 0; i < 5; i++) begin
            settle();
            chk1("bp_mul_e", mul_e, 1'b0);
            chk1("bp_req0_ready", req0_ready, 1'b0);
            chk1("bp_req1_ready", req1_ready, 1'b0);
            chk1("bp_res_valid", res_valid, 1'b1);
            chk1("bp_res_id", res_id, 1'b0);
            chk32("bp_res_z", res_z, 32'h40000000);
            tick();
        end
        res_ready = 1'b1;
        drive0(1'b0, 32'd0, 32'd0, 2'd0);
        drive1(1'b0, 32'd0, 32'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check_result("bp_release");
            tick();
        end
        settle();
        chk1("bp_after_valid", res_valid, 1'b0);
        chk1("bp_after_busy", busy, 1'b0);

        // Bubble: issue, idle, issue with the consumer stalled throughout
        res_ready = 1'b0;
        drive0(1'b1, 32'h40400000, 32'h40400000, 2'd0);
        settle();
        chk1("bub_mul_e_empty_out", mul_e, 1'b1);
        chk1("bub_req0_ready", req0_ready, 1'b1);
        exp_q.push_back({1'b0, 32'h41100000});
        tick();
        drive0(1'b0, 32'd0, 32'd0, 2'd0);
        settle();
        chk1("bub_idle_valid", res_valid, 1'b0);
        tick();
        drive1(1'b1, 32'h40000000, 32'h40000000, 2'd0);
        settle();
        chk1("bub_req1_ready", req1_ready, 1'b1);
        exp_q.push_back({1'b1, 32'h40800000});
        tick();
        drive1(1'b0, 32'd0, 32'd0, 2'd0);
        settle();
        chk1("bub_stall_mul_e", mul_e, 1'b0);
        chk1("bub_stall_valid", res_valid, 1'b1);
        chk32("bub_stall_z", res_z, 32'h41100000);
        tick();
        settle();
        chk32("bub_hold_z", res_z, 32'h41100000);
        chk1("bub_hold_busy", busy, 1'b1);
        res_ready = 1'b1;
        settle();
        check_result("bub_first");
        tick();
        settle();
        chk1("bub_gap_valid", res_valid, 1'b0);
        tick();
        settle();
        check_result("bub_second");
        tick();
        settle();
        chk1("bub_after_busy", busy, 1'b0);

        // Flush with two operations in flight and requester 0 asking
        res_ready = 1'b1;
        drive0(1'b1, 32'h3F800000, 32'h40400000, 2'd0);
        settle();
        chk1("fl_issue0_ready", req0_ready, 1'b1);
        tick();
        drive0(1'b0, 32'd0, 32'd0, 2'd0);
        drive1(1'b1, 32'h40000000, 32'h40400000, 2'd0);
        settle();
        chk1("fl_issue1_ready", req1_ready, 1'b1);
        tick();
        drive1(1'b0, 32'd0, 32'd0, 2'd0);
        drive0(1'b1, 32'h40000000, 32'h40000000, 2'd0);
        flush = 1'b1;
        settle();
        chk1("fl_req0_ready", req0_ready, 1'b0);
        chk32("fl_mul_a", mul_a, 32'h00000000);
        chk1("fl_busy_during", busy, 1'b1);
        tick();
        flush = 1'b0;
        drive0(1'b0, 32'd0, 32'd0, 2'd0);
        settle();
        chk1("fl_busy_after", busy, 1'b0);
        chk1("fl_valid_after", res_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            settle();
            chk1("fl_no_result", res_valid, 1'b0);
        end
        // Last grant before the flush went to requester 1, so requester 0 wins now.
        drive0(1'b1, 32'h40000000, 32'h40000000, 2'd0);
        drive1(1'b1, 32'h40400000, 32'h40400000, 2'd0);
        settle();
        chk1("fl_rr_req0_ready", req0_ready, 1'b1);
        chk1("fl_rr_req1_ready", req1_ready, 1'b0);
        exp_q.push_back({1'b0, 32'h40800000});
        tick();
        drive0(1'b0, 32'd0, 32'd0, 2'd0);
        drive1(1'b0, 32'd0, 32'd0, 2'd0);
        settle();
        drain("fl_post", 10);

        // Asynchronous reset with three operations in flight
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive0(1'b1, 32'h3FC00000, 32'h3FC00000, 2'd0);
            settle();
            chk1("rmid_issue_ready", req0_ready, 1'b1);
            tick();
        end
        drive0(1'b0, 32'd0, 32'd0, 2'd0);
        settle();
        chk1("rmid_pre_valid", res_valid, 1'b1);
        #2;
        clrn = 1'b0;
        #1;
        chk1("rmid_valid", res_valid, 1'b0);
        chk1("rmid_busy", busy, 1'b0);
        chk1("rmid_mul_e", mul_e, 1'b1);
        tick();
        clrn = 1'b1;
        settle();
        chk1("rpost_valid", res_valid, 1'b0);
        chk1("rpost_busy", busy, 1'b0);
        drive0(1'b1, 32'h40400000, 32'h40400000, 2'd0);
        drive1(1'b1, 32'h40000000, 32'h40000000, 2'd0);
        settle();
        chk1("rpost_req0_ready", req0_ready, 1'b1);
        chk1("rpost_req1_ready", req1_ready, 1'b0);
        exp_q.push_back({1'b0, 32'h41100000});
        tick();
        drive0(1'b0, 32'd0, 32'd0, 2'd0);
        drive1(1'b0, 32'd0, 32'd0, 2'd0);
        settle();
        drain("rpost", 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
